// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared types and constants for the round-robin encoder arbiter.
package rr_encoder_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Rotate right by s: result[0] is v[s], so searching result from bit 0
  // walks the requesters starting at s and wrapping through 7 -> 0.
  function automatic logic [NREQ-1:0] rotr(input logic [NREQ-1:0] v,
                                           input logic [IDX_W-1:0] s);
    logic [2*NREQ-1:0] d;
    d = {v, v};
    return d[s +: NREQ];
  endfunction

endpackage

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The owner-done strobe is named rel because "release" is a reserved word.
interface rr_encoder_arbiter_if;
  import rr_encoder_arbiter_pkg::*;

  logic                   enable;
  logic [NREQ-1:0]        req;
  logic                   rel;
  logic [NREQ-1:0]        grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   timeout;

  modport master (
    output enable, req, rel,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  enable, req, rel,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_encoder_arbiter_encoder.sv
// 8-to-3 lowest-set-bit priority encoder with enable.
module encoder_8to3_en
  import rr_encoder_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  in,
  input  logic             enable,
  output logic [IDX_W-1:0] out,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    out = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (in[i]) out = IDX_W'(i);
    end
    valid = (|in) & enable;
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 8 requesters: one grant at a time, bounded hold,
// forced idle gap between grants, just-served requester drops to lowest priority.
module rr_encoder_arbiter
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_encoder_arbiter_if.slave  bus
);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [NREQ-1:0]  grant_n;
  logic [IDX_W-1:0] idx_n;
  logic             gv_n, to_n;

  logic [NREQ-1:0]  req_rot;
  logic [IDX_W-1:0] enc_out;
  logic             enc_valid;
  logic [IDX_W-1:0] winner;
  logic             hold_max;
  logic             owner_req;

  // Search order starts at ptr; the encoder result is an offset from ptr.
  assign req_rot   = rotr(bus.req, ptr);
  assign winner    = enc_out + ptr;
  assign hold_max  = (hold_cnt == CNT_W'(MAX_HOLD));
  assign owner_req = bus.req[bus.grant_idx];

  encoder_8to3_en u_enc (
    .in     (req_rot),
    .enable (bus.enable),
    .out    (enc_out),
    .valid  (enc_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    grant_n = bus.grant;
    idx_n   = bus.grant_idx;
    gv_n    = bus.grant_valid;
    to_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_n = '0;
        gv_n    = 1'b0;
        if (enc_valid) begin
          state_n = ST_GRANT;
          grant_n = NREQ'(1) << winner;
          idx_n   = winner;
          gv_n    = 1'b1;
          hold_n  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // enable is deliberately ignored here: it only gates new grants.
        if (bus.rel || !owner_req || hold_max) begin
          state_n = ST_IDLE;
          grant_n = '0;
          gv_n    = 1'b0;
          ptr_n   = bus.grant_idx + IDX_W'(1);
          // A release in the same cycle as the limit wins: no timeout.
          to_n    = hold_max & ~bus.rel & owner_req;
        end else begin
          hold_n  = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset overrides everything, including an active grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.grant_idx   <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      state           <= state_n;
      ptr             <= ptr_n;
      hold_cnt        <= hold_n;
      bus.grant       <= grant_n;
      bus.grant_idx   <= idx_n;
      bus.grant_valid <= gv_n;
      bus.timeout     <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter: expected outputs are queued per
// cycle as stimulus is applied and compared one cycle later.
module tb_rr_encoder_arbiter;

  typedef struct packed {
    logic       gv;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  rr_encoder_arbiter_if bus ();

  rr_encoder_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, advance one clock, then compare 1 time unit later.
  task automatic cyc(input string tag, input logic gv, input logic [7:0] g,
                     input logic [2:0] idx, input logic to);
    exp_t e;
    sb.push_back('{gv: gv, grant: g, idx: idx, to: to});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk1({tag, ".grant_valid"}, {7'd0, bus.grant_valid}, {7'd0, e.gv});
    chk1({tag, ".grant"},       bus.grant,               e.grant);
    chk1({tag, ".grant_idx"},   {5'd0, bus.grant_idx},   {5'd0, e.idx});
    chk1({tag, ".timeout"},     {7'd0, bus.timeout},     {7'd0, e.to});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.req = 8'h00;
    bus.rel = 1'b0;
    @(negedge clk);

    // 1: reset state
    cyc("rst0", 0, 8'h00, 3'd0, 0);
    cyc("rst1", 0, 8'h00, 3'd0, 0);
    rst_n = 1'b1;
    cyc("idle_noreq", 0, 8'h00, 3'd0, 0);

    // 2: two requesters, release, one idle cycle, next one from ptr
    bus.enable = 1'b1;
    bus.req = 8'b0010_0100;
    cyc("t2_g2", 1, 8'h04, 3'd2, 0);
    bus.rel = 1'b1;
    cyc("t2_rel2", 0, 8'h00, 3'd2, 0);
    bus.rel = 1'b0;
    cyc("t2_g5", 1, 8'h20, 3'd5, 0);
    bus.rel = 1'b1;
    cyc("t2_rel5", 0, 8'h00, 3'd5, 0);

    // 3: full load rotation from ptr=0, one idle gap each grant
    rst_n = 1'b0;
    bus.rel = 1'b0;
    bus.req = 8'hFF;
    cyc("t3_rst", 0, 8'h00, 3'd0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.rel = 1'b0;
      cyc("t3_grant", 1, oh(k % 8), 3'(k % 8), 0);
      bus.rel = 1'b1;
      cyc("t3_gap", 0, 8'h00, 3'(k % 8), 0);
    end

    // 4: hold limit -> timeout pulse, gap, regrant; then release at the limit
    bus.rel = 1'b0;
    bus.req = 8'h01;
    for (int k = 0; k < 16; k++) cyc("t4_hold", 1, 8'h01, 3'd0, 0);
    cyc("t4_timeout", 0, 8'h00, 3'd0, 1);
    cyc("t4_regrant", 1, 8'h01, 3'd0, 0);
    for (int k = 0; k < 15; k++) cyc("t4_hold2", 1, 8'h01, 3'd0, 0);
    bus.rel = 1'b1;
    cyc("t4_rel_at_max", 0, 8'h00, 3'd0, 0);

    // 5: enable low during grant keeps it; no new grant while enable=0
    bus.rel = 1'b0;
    bus.req = 8'h08;
    cyc("t5_g3", 1, 8'h08, 3'd3, 0);
    bus.enable = 1'b0;
    cyc("t5_hold_en0", 1, 8'h08, 3'd3, 0);
    bus.req = 8'hFF;
    cyc("t5_hold_others", 1, 8'h08, 3'd3, 0);
    bus.rel = 1'b1;
    cyc("t5_rel", 0, 8'h00, 3'd3, 0);
    bus.rel = 1'b0;
    for (int k = 0; k < 3; k++) cyc("t5_no_grant", 0, 8'h00, 3'd3, 0);

    // owner dropping its request ends the grant without timeout
    bus.enable = 1'b1;
    cyc("t5_g4", 1, 8'h10, 3'd4, 0);
    bus.req = 8'hEF;
    cyc("t5_drop", 0, 8'h00, 3'd4, 0);

    // 6: reset mid-grant clears outputs and ptr
    bus.req = 8'h40;
    cyc("t6_g6", 1, 8'h40, 3'd6, 0);
    rst_n = 1'b0;
    cyc("t6_rst", 0, 8'h00, 3'd0, 0);
    rst_n = 1'b1;
    bus.req = 8'h41;
    cyc("t6_g0", 1, 8'h01, 3'd0, 0);
    bus.rel = 1'b1;
    cyc("t6_rel", 0, 8'h00, 3'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
